// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Grants are locked per burst; each written word carries the source index as a tag.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                     wclk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_wr_en,
    output logic [WIDTH+IDW-1:0]     fifo_din,
    input  logic                     fifo_wfull,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);
    localparam int          CW = $clog2(MAX_BURST + 1);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] rr_next;
    logic           found;
    logic           g_valid;
    logic           g_last;
    logic [WIDTH-1:0] g_data;
    int unsigned    idx;

    // Port-facing outputs follow the granted requester with zero latency.
    always_comb begin
        g_valid    = req_valid[grant_id_q];
        g_last     = req_last[grant_id_q];
        g_data     = req_data[int'(grant_id_q)*WIDTH +: WIDTH];
        busy       = (state_q == BURST);
        grant_id   = grant_id_q;
        fifo_din   = {grant_id_q, g_data};
        fifo_wr_en = busy && g_valid && !fifo_wfull;
        req_ready  = '0;
        if (busy && !fifo_wfull) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        found      = 1'b0;
        winner     = '0;
        idx        = 0;
        rr_next    = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

        // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ (not at 2**IDW).
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (32'(rr_ptr_q) + i) % NR;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BURST;
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (fifo_wr_en) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (g_last || beat_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next;
                    end
                end else if (!g_valid && !fifo_wfull) begin
                    // Source went quiet: hand the port back rather than hold it idle.
                    state_d  = IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench for fifo_wr_arbiter: queued requester sources, expected
// FIFO words queued by hand, and a negedge monitor that checks every write.
module tb_fifo_wr_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             wclk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_wr_en;
    logic [W+IDW-1:0] fifo_din;
    logic             fifo_wfull;
    logic [IDW-1:0]   grant_id;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  src_mem  [N][16];
    int unsigned src_head [N];
    int unsigned src_len  [N];
    logic [N-1:0] fire_r = '0;
    logic [9:0]  exp_q [$];

    fifo_wr_arbiter #(
        .WIDTH    (W),
        .NUM_REQ  (N),
        .MAX_BURST(4)
    ) dut (
        .wclk      (wclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .fifo_wfull(fifo_wfull),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the next expected tagged word.
    always @(negedge wclk) begin
        fire_r = req_valid & req_ready;
        if (fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got %0h expected no write", fifo_din);
            end else begin
                chk("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_src(input int r, input logic [7:0] d, input logic last);
        src_mem[r][src_len[r]] = {last, d};
        src_len[r]++;
    endtask

    task automatic push_exp(input int r, input logic [7:0] d);
        exp_q.push_back({2'(r), d});
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (src_head[r] < src_len[r]) begin
                req_valid[r]        = 1'b1;
                req_last[r]         = src_mem[r][src_head[r]][8];
                req_data[r*W +: W]  = src_mem[r][src_head[r]][7:0];
            end else begin
                req_valid[r]        = 1'b0;
                req_last[r]         = 1'b0;
                req_data[r*W +: W]  = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (fire_r[r]) src_head[r]++;
        end
        drive();
        #1;
    endtask

    task automatic clear_src();
        for (int r = 0; r < N; r++) begin
            src_head[r] = 0;
            src_len[r]  = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_wfull = 1'b0;
        clear_src();
        exp_q.delete();
        drive();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        fifo_wfull = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        clear_src();
        drive();
        tick();
        tick();

        // Test 1: single requester, 4-beat packet ending with last
        for (int b = 0; b < 4; b++) begin
            push_src(0, 8'(8'h11 + b), (b == 3));
            push_exp(0, 8'(8'h11 + b));
        end
        drive();
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        chk("reset_din", 32'(fifo_din), 32'h011);
        rst_n = 1'b1;
        tick();
        chk("t1_busy_after_arb", 32'(busy), 32'd1);
        chk("t1_grant", 32'(grant_id), 32'd0);
        n = 0;
        for (int k = 0; k < 8 && busy; k++) begin
            n++;
            tick();
        end
        chk("t1_busy_cycles", 32'(n), 32'd4);
        drain("t1_drain", 20);

        // rr_ptr is now 1: requester 1 beats requester 0
        push_src(0, 8'h21, 1'b1);
        push_src(1, 8'h22, 1'b1);
        push_exp(1, 8'h22);
        push_exp(0, 8'h21);
        drive();
        drain("t1b_drain", 20);

        // Test 2: all four valid, no last; 4-beat bursts in order 0,1,2,3,0,...
        do_reset();
        for (int r = 0; r < N; r++)
            for (int b = 0; b < 8; b++)
                push_src(r, 8'(8'h30 + r*16 + b), 1'b0);
        for (int rd = 0; rd < 2; rd++)
            for (int r = 0; r < N; r++)
                for (int b = 0; b < 4; b++)
                    push_exp(r, 8'(8'h30 + r*16 + rd*4 + b));
        drive();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (fifo_wr_en) n++;
        end
        chk("t2_throughput", 32'(n), 32'd32);
        drain("t2_drain", 20);

        // Test 3: requester 2 stalled by wfull for 5 cycles after beat 2
        do_reset();
        for (int b = 0; b < 4; b++) begin
            push_src(2, 8'(8'h51 + b), 1'b0);
            push_exp(2, 8'(8'h51 + b));
        end
        drive();
        tick();
        chk("t3_grant", 32'(grant_id), 32'd2);
        tick();
        tick();
        fifo_wfull = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_full_ready", 32'(req_ready), 32'd0);
            chk("t3_full_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("t3_full_grant", 32'(grant_id), 32'd2);
            tick();
        end
        fifo_wfull = 1'b0;
        drain("t3_drain", 20);

        // Test 4: requester 1 drops valid after one beat; bubble releases grant
        do_reset();
        push_src(1, 8'h61, 1'b0);
        push_src(3, 8'h71, 1'b0);
        push_src(3, 8'h72, 1'b1);
        push_exp(1, 8'h61);
        push_exp(3, 8'h71);
        push_exp(3, 8'h72);
        drive();
        tick();
        chk("t4_grant1", 32'(grant_id), 32'd1);
        tick();
        chk("t4_bubble_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t4_bubble_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_released", 32'(busy), 32'd0);
        push_src(1, 8'h62, 1'b1);
        push_exp(1, 8'h62);
        drive();
        tick();
        chk("t4_grant3", 32'(grant_id), 32'd3);
        drain("t4_drain", 20);

        // Test 5: last on beat 4 coincides with the burst limit
        do_reset();
        for (int b = 0; b < 4; b++) begin
            push_src(0, 8'(8'h81 + b), (b == 3));
            push_exp(0, 8'(8'h81 + b));
        end
        push_src(1, 8'h91, 1'b1);
        push_src(2, 8'hA1, 1'b1);
        push_exp(1, 8'h91);
        push_exp(2, 8'hA1);
        drive();
        for (int k = 0; k < 5; k++) tick();
        chk("t5_single_idle", 32'(busy), 32'd0);
        tick();
        chk("t5_next_busy", 32'(busy), 32'd1);
        chk("t5_next_grant", 32'(grant_id), 32'd1);
        drain("t5_drain", 20);

        // Test 6: async reset during beat 2 (rr_ptr is 3 beforehand)
        push_src(0, 8'hB1, 1'b0);
        push_src(0, 8'hB2, 1'b0);
        push_src(0, 8'hB3, 1'b0);
        push_src(0, 8'hB4, 1'b0);
        push_exp(0, 8'hB1);
        drive();
        tick();
        chk("t6_grant0", 32'(grant_id), 32'd0);
        tick();
        push_src(1, 8'hD1, 1'b1);
        push_src(2, 8'hE1, 1'b1);
        push_src(3, 8'hF1, 1'b1);
        drive();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        chk("t6_rst_wr_en_held", 32'(fifo_wr_en), 32'd0);
        chk("t6_rst_ready_held", 32'(req_ready), 32'd0);
        push_exp(0, 8'hB2);
        push_exp(0, 8'hB3);
        push_exp(0, 8'hB4);
        push_exp(1, 8'hD1);
        push_exp(2, 8'hE1);
        push_exp(3, 8'hF1);
        rst_n = 1'b1;
        #1;
        chk("t6_grant_after_rst", 32'(grant_id), 32'd0);
        tick();
        chk("t6_first_busy", 32'(busy), 32'd1);
        chk("t6_first_grant", 32'(grant_id), 32'd0);
        drain("t6_drain", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
